parametros_tempo: RTL and testbench

- Time-parameter store for the alarm/timer controller.
- Holds four programmable 4-bit durations, in seconds:
  - 00 arm delay
  - 01 driver delay
  - 10 passenger delay
  - 11 alarm-on
- Presents the duration chosen by `interval` as a registered 5-bit `value` to the downstream second-counter/timer.
- Durations can be reprogrammed at run time; reset restores the factory defaults.

---
 rtl/parametros_tempo.sv | 71 +++++++
 tb/tb_parametros_tempo.sv | 107 ++++++++++
 2 files changed

// File: rtl/parametros_tempo.sv
// Time-parameter store for the alarm/timer controller: four programmable
// durations with factory defaults, one selected onto a registered output.

module parametros_tempo_reg #(
  parameter int              PW      = 4,
  parameter logic [PW-1:0]   DEFAULT = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr,
  input  logic [PW-1:0] din,
  output logic [PW-1:0] q
);
  // A zero duration would stall the timer, so writing 0 restores the default.
  always_ff @(posedge clock) begin
    if (!reset)  q <= DEFAULT;
    else if (wr) q <= (din == '0) ? DEFAULT : din;
  end
endmodule

module parametros_tempo #(
  parameter int T_ARM_DEFAULT       = 6,
  parameter int T_DRIVER_DEFAULT    = 8,
  parameter int T_PASSENGER_DEFAULT = 15,
  parameter int T_ALARM_DEFAULT     = 10,
  parameter int PW                  = 4,
  parameter int VW                  = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    time_param_sel,
  input  logic [1:0]    interval,
  input  logic [PW-1:0] time_value,
  input  logic          reprogram,
  output logic [VW-1:0] value
);
  localparam int NUM_P = 4;

  // Index order matches the select encoding: 0 arm, 1 driver, 2 passenger, 3 alarm.
  localparam logic [NUM_P-1:0][PW-1:0] DEFAULTS = {
    PW'(T_ALARM_DEFAULT), PW'(T_PASSENGER_DEFAULT),
    PW'(T_DRIVER_DEFAULT), PW'(T_ARM_DEFAULT)
  };

  logic [NUM_P-1:0][PW-1:0] params;
  logic [NUM_P-1:0]         wr;

  always_comb begin
    wr = '0;
    wr[time_param_sel] = reprogram;
  end

  for (genvar i = 0; i < NUM_P; i++) begin : g_param
    parametros_tempo_reg #(
      .PW      (PW),
      .DEFAULT (DEFAULTS[i])
    ) u_reg (
      .clock (clock),
      .reset (reset),
      .wr    (wr[i]),
      .din   (time_value),
      .q     (params[i])
    );
  end

  // Reads the pre-write contents, so a same-cycle write shows one edge later.
  always_ff @(posedge clock) begin
    if (!reset) value <= '0;
    else        value <= VW'(params[interval]);
  end
endmodule

// File: tb/tb_parametros_tempo.sv
// Self-checking bench: directed test-plan sequences plus random traffic
// compared against an array-based reference model.

module tb_parametros_tempo;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] time_param_sel;
  logic [1:0] interval;
  logic [3:0] time_value;
  logic       reprogram;
  logic [4:0] value;

  int n_chk  = 0;
  int n_fail = 0;

  int dflt [4] = '{6, 8, 15, 10};
  int mreg [4];
  int mval;

  parametros_tempo dut (
    .clock          (clock),
    .reset          (reset),
    .time_param_sel (time_param_sel),
    .interval       (interval),
    .time_value     (time_value),
    .reprogram      (reprogram),
    .value          (value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic rp, input int s,
                      input int tv, input int iv);
    @(negedge clock);
    reset = r; reprogram = rp;
    time_param_sel = 2'(s); time_value = 4'(tv); interval = 2'(iv);
    @(posedge clock);
    if (!r) begin
      foreach (mreg[k]) mreg[k] = dflt[k];
      mval = 0;
    end else begin
      mval = mreg[iv];
      if (rp) mreg[s] = (tv == 0) ? dflt[s] : tv;
    end
    #1;
    chk("model", int'(value), mval);
    chk("msb_zero", int'(value[4]), 0);
  endtask

  initial begin
    foreach (mreg[k]) mreg[k] = dflt[k];
    mval = 0;

    // reset, then alarm default held
    step(0, 0, 0, 0, 3); chk("reset_value", int'(value), 0);
    step(1, 0, 0, 0, 3); chk("post_reset_alarm", int'(value), 10);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 3); chk("hold_alarm", int'(value), 10);
    end

    // defaults
    step(1, 0, 0, 0, 0); chk("dflt_arm", int'(value), 6);
    step(1, 0, 0, 0, 1); chk("dflt_drv", int'(value), 8);
    step(1, 0, 0, 0, 2); chk("dflt_pas", int'(value), 15);
    step(1, 0, 0, 0, 3); chk("dflt_alm", int'(value), 10);

    // driver write
    step(1, 1, 1, 5, 0); chk("arm_during_wr", int'(value), 6);
    step(1, 0, 0, 0, 1); chk("drv_written", int'(value), 5);
    step(1, 0, 0, 0, 0); chk("arm_untouched", int'(value), 6);

    // write the parameter being displayed
    step(1, 0, 0, 0, 2); chk("pas_before", int'(value), 15);
    step(1, 1, 2, 3, 2); chk("pas_wr_edge_old", int'(value), 15);
    step(1, 0, 0, 0, 2); chk("pas_next_new", int'(value), 3);

    // zero rule on alarm
    step(1, 1, 3, 4, 3); chk("alm_before_wr", int'(value), 10);
    step(1, 0, 0, 0, 3); chk("alm_set4", int'(value), 4);
    step(1, 1, 3, 0, 3); chk("alm_zero_wr_edge", int'(value), 4);
    step(1, 0, 0, 0, 3); chk("alm_zero_restores", int'(value), 10);

    // reset discards driver=5 and overrides a concurrent write
    step(1, 0, 0, 0, 1); chk("drv_still5", int'(value), 5);
    step(0, 1, 1, 7, 1); chk("reset_cycle_value", int'(value), 0);
    step(1, 0, 0, 0, 1); chk("drv_back_default", int'(value), 8);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
